// File: rtl/satatrn_pkg.sv
// Shared SATA transport-layer definitions: FIS type codes, receive-side
// state encoding, captured-field and strobe bundles, expected FIS lengths.
package satatrn_pkg;

   localparam logic [7:0] FIS_REG_D2H   = 8'h34;
   localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
   localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
   localparam logic [7:0] FIS_SDB       = 8'hA1;
   localparam logic [7:0] FIS_BIST      = 8'h58;
   localparam logic [7:0] FIS_DATA      = 8'h46;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN
   } rx_state_t;

   typedef struct packed {
      logic        irq;
      logic [7:0]  status;
      logic [7:0]  error;
      logic [47:0] lba;
      logic [15:0] count;
      logic [15:0] xfer_len;
   } fis_fields_t;

   typedef struct packed {
      logic d2h;
      logic pio;
      logic dmaact;
      logic sdb;
      logic bist;
   } fis_stb_t;

   // Length in dwords; 0 marks a type the receive path does not accept.
   // Data FIS never reaches the register path, so it is treated as unknown.
   function automatic logic [3:0] fis_exp_len(input logic [7:0] fis_type,
                                              input logic       opt_bist);
      case (fis_type)
         FIS_REG_D2H:   fis_exp_len = 4'd5;
         FIS_PIO_SETUP: fis_exp_len = 4'd5;
         FIS_DMA_ACT:   fis_exp_len = 4'd1;
         FIS_SDB:       fis_exp_len = 4'd2;
         FIS_BIST:      fis_exp_len = opt_bist ? 4'd3 : 4'd0;
         FIS_DATA:      fis_exp_len = 4'd0;
         default:       fis_exp_len = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/satatrn_fislen.sv
// FIS type to expected length lookup; purely combinational, shared with TX.
module satatrn_fislen
   import satatrn_pkg::*;
#(
   parameter logic OPT_BIST = 1'b0
) (
   input  logic [7:0] fis_type,
   output logic [3:0] exp_len,
   output logic       known
);

   assign exp_len = fis_exp_len(fis_type, OPT_BIST);
   assign known   = (exp_len != 4'd0);

endmodule

// File: rtl/satatrn_rxfis_ctrl.sv
// Register-FIS receive controller: parses the non-data FIS stream, checks
// length against type, captures command fields and pulses per-type strobes.
module satatrn_rxfis_ctrl
   import satatrn_pkg::*;
#(
   parameter logic OPT_BIST     = 1'b0,
   parameter logic OPT_LOWPOWER = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_abort,
   input  logic        i_reg_valid,
   input  logic [31:0] i_reg_data,
   input  logic        i_reg_last,
   output logic        o_busy,
   output logic        o_d2h_stb,
   output logic        o_pio_stb,
   output logic        o_dmaact_stb,
   output logic        o_sdb_stb,
   output logic        o_bist_stb,
   output logic        o_irq,
   output logic [7:0]  o_status,
   output logic [7:0]  o_error,
   output logic [47:0] o_lba,
   output logic [15:0] o_count,
   output logic [15:0] o_xfer_len,
   output logic        o_fis_err
);

   rx_state_t   state, state_nxt;
   logic [3:0]  cnt, cnt_nxt, cnt_inc;
   logic [3:0]  exp_q, exp_nxt;
   logic [7:0]  type_q, type_nxt;
   fis_fields_t stg, stg_nxt, out_q;
   fis_stb_t    stb_q, stb_nxt;
   logic        err_q;
   logic        accept, err;
   logic [3:0]  word_len;
   logic        word_known;
   logic        has_lba;

   satatrn_fislen #(.OPT_BIST(OPT_BIST)) u_fislen (
      .fis_type (i_reg_data[31:24]),
      .exp_len  (word_len),
      .known    (word_known)
   );

   assign cnt_inc = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
   assign has_lba = (type_q == FIS_REG_D2H) || (type_q == FIS_PIO_SETUP);

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
      state_nxt = state;
      cnt_nxt   = cnt;
      exp_nxt   = exp_q;
      type_nxt  = type_q;
      stg_nxt   = stg;
      accept    = 1'b0;
      err       = 1'b0;
      if (i_reg_valid) begin
         case (state)
            ST_IDLE: begin
               type_nxt       = i_reg_data[31:24];
               exp_nxt        = word_len;
               cnt_nxt        = 4'd1;
               stg_nxt        = '0;
               stg_nxt.irq    = i_reg_data[14];
               stg_nxt.status = i_reg_data[15:8];
               stg_nxt.error  = i_reg_data[7:0];
               if (!word_known) begin
                  if (i_reg_last) err = 1'b1;
                  else            state_nxt = ST_DRAIN;
               end else if (word_len == 4'd1) begin
                  if (i_reg_last) accept = 1'b1;
                  else            state_nxt = ST_DRAIN;
               end else if (i_reg_last) begin
                  err = 1'b1;
               end else begin
                  state_nxt = ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               cnt_nxt = cnt_inc;
               // Dwords carry byte 0 in the top lane, so multi-byte fields are byte-swapped.
               case (cnt)
                  4'd1: if (has_lba) stg_nxt.lba[31:0] = {i_reg_data[7:0], i_reg_data[15:8],
                                                          i_reg_data[23:16], i_reg_data[31:24]};
                  4'd2: if (has_lba) stg_nxt.lba[47:32] = {i_reg_data[23:16], i_reg_data[31:24]};
                  4'd3: if (has_lba) begin
                     stg_nxt.count = {i_reg_data[23:16], i_reg_data[31:24]};
                     if (type_q == FIS_PIO_SETUP) stg_nxt.status = i_reg_data[7:0];
                  end
                  4'd4: if (type_q == FIS_PIO_SETUP)
                     stg_nxt.xfer_len = {i_reg_data[23:16], i_reg_data[31:24]};
                  default: ;
               endcase
               if (i_reg_last) begin
                  state_nxt = ST_IDLE;
                  if (cnt_inc == exp_q) accept = 1'b1;
                  else                  err    = 1'b1;
               end else if (cnt_inc == exp_q) begin
                  state_nxt = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_reg_last) begin
                  err       = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
      if (i_abort) begin
         state_nxt = ST_IDLE;
         accept    = 1'b0;
         err       = 1'b0;
      end
   end

   always_comb begin
      stb_nxt = '0;
      if (accept) begin
         case (type_nxt)
            FIS_REG_D2H:   stb_nxt.d2h    = 1'b1;
            FIS_PIO_SETUP: stb_nxt.pio    = 1'b1;
            FIS_DMA_ACT:   stb_nxt.dmaact = 1'b1;
            FIS_SDB:       stb_nxt.sdb    = 1'b1;
            FIS_BIST:      stb_nxt.bist   = OPT_BIST;
            default:       stb_nxt        = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         exp_q  <= '0;
         type_q <= '0;
         stg    <= '0;
         stb_q  <= '0;
         err_q  <= 1'b0;
         out_q  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         exp_q  <= exp_nxt;
         type_q <= type_nxt;
         stg    <= stg_nxt;
         stb_q  <= stb_nxt;
         err_q  <= err;
         // Outputs load from the next-staging value so the last word's fields land with the strobe.
         if (accept)            out_q <= stg_nxt;
         else if (OPT_LOWPOWER) out_q <= '0;
      end
   end

   assign o_busy       = (state != ST_IDLE);
   assign o_d2h_stb    = stb_q.d2h;
   assign o_pio_stb    = stb_q.pio;
   assign o_dmaact_stb = stb_q.dmaact;
   assign o_sdb_stb    = stb_q.sdb;
   assign o_bist_stb   = stb_q.bist;
   assign o_fis_err    = err_q;
   assign o_irq        = out_q.irq;
   assign o_status     = out_q.status;
   assign o_error      = out_q.error;
   assign o_lba        = out_q.lba;
   assign o_count      = out_q.count;
   assign o_xfer_len   = out_q.xfer_len;

endmodule

// File: tb/tb_satatrn_rxfis_ctrl.sv
// Directed bench for satatrn_rxfis_ctrl: hand-computed expectations per step.
module tb_satatrn_rxfis_ctrl;

   logic        i_clk;
   logic        i_reset_n;
   logic        i_abort;
   logic        i_reg_valid;
   logic [31:0] i_reg_data;
   logic        i_reg_last;
   logic        o_busy;
   logic        o_d2h_stb;
   logic        o_pio_stb;
   logic        o_dmaact_stb;
   logic        o_sdb_stb;
   logic        o_bist_stb;
   logic        o_irq;
   logic [7:0]  o_status;
   logic [7:0]  o_error;
   logic [47:0] o_lba;
   logic [15:0] o_count;
   logic [15:0] o_xfer_len;
   logic        o_fis_err;

   int n_cmp = 0;
   int n_err = 0;

   satatrn_rxfis_ctrl dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_abort      (i_abort),
      .i_reg_valid  (i_reg_valid),
      .i_reg_data   (i_reg_data),
      .i_reg_last   (i_reg_last),
      .o_busy       (o_busy),
      .o_d2h_stb    (o_d2h_stb),
      .o_pio_stb    (o_pio_stb),
      .o_dmaact_stb (o_dmaact_stb),
      .o_sdb_stb    (o_sdb_stb),
      .o_bist_stb   (o_bist_stb),
      .o_irq        (o_irq),
      .o_status     (o_status),
      .o_error      (o_error),
      .o_lba        (o_lba),
      .o_count      (o_count),
      .o_xfer_len   (o_xfer_len),
      .o_fis_err    (o_fis_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word for exactly one rising edge, then look 1 ns after it.
   task automatic word(input logic [31:0] d, input logic last);
      i_reg_valid = 1'b1;
      i_reg_data  = d;
      i_reg_last  = last;
      @(posedge i_clk);
      #1;
      i_reg_valid = 1'b0;
      i_reg_last  = 1'b0;
      i_reg_data  = '0;
   endtask

   task automatic idle();
      i_reg_valid = 1'b0;
      i_reg_last  = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset_n   = 1'b0;
      i_abort     = 1'b0;
      i_reg_valid = 1'b0;
      i_reg_data  = '0;
      i_reg_last  = 1'b0;
      #1;
      check("rst_busy",   o_busy,    0);
      check("rst_d2h",    o_d2h_stb, 0);
      check("rst_err",    o_fis_err, 0);
      check("rst_status", o_status,  0);
      check("rst_lba",    o_lba,     0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      idle();

      // Register D2H, 5 words
      word(32'h34405001, 1'b0);
      check("d2h_busy_w0", o_busy, 1);
      word(32'h11223344, 1'b0);
      word(32'h55660000, 1'b0);
      word(32'h02010000, 1'b0);
      check("d2h_no_early_stb", o_d2h_stb, 0);
      word(32'h00000000, 1'b1);
      check("d2h_stb",    o_d2h_stb,  1);
      check("d2h_pio",    o_pio_stb,  0);
      check("d2h_err",    o_fis_err,  0);
      check("d2h_status", o_status,   8'h50);
      check("d2h_error",  o_error,    8'h01);
      check("d2h_irq",    o_irq,      1);
      check("d2h_lba",    o_lba,      48'h665544332211);
      check("d2h_count",  o_count,    16'h0102);
      check("d2h_busy",   o_busy,     0);
      idle();
      check("d2h_stb_pulse", o_d2h_stb, 0);
      check("d2h_hold",      o_status,  8'h50);

      // PIO Setup, E_status from word3, transfer count from word4
      word(32'h5F002000, 1'b0);
      word(32'h01020304, 1'b0);
      word(32'h05060000, 1'b0);
      word(32'h000000D0, 1'b0);
      word(32'h00020000, 1'b1);
      check("pio_stb",    o_pio_stb,  1);
      check("pio_d2h",    o_d2h_stb,  0);
      check("pio_status", o_status,   8'hD0);
      check("pio_xfer",   o_xfer_len, 16'h0200);
      check("pio_lba",    o_lba,      48'h060504030201);
      check("pio_count",  o_count,    16'h0000);
      check("pio_irq",    o_irq,      0);
      idle();

      // DMA Activate then SDB back to back
      word(32'h39000000, 1'b1);
      check("dma_stb",    o_dmaact_stb, 1);
      check("dma_status", o_status,     8'h00);
      word(32'hA1404501, 1'b0);
      check("dma_pulse",  o_dmaact_stb, 0);
      check("sdb_early",  o_sdb_stb,    0);
      check("sdb_busy",   o_busy,       1);
      word(32'h00000000, 1'b1);
      check("sdb_stb",    o_sdb_stb,    1);
      check("sdb_err",    o_fis_err,    0);
      check("sdb_status", o_status,     8'h45);
      check("sdb_error",  o_error,      8'h01);
      check("sdb_irq",    o_irq,        1);
      idle();

      // Short D2H: last on word 3
      word(32'h34007F00, 1'b0);
      word(32'hAAAAAAAA, 1'b0);
      word(32'hBBBBBBBB, 1'b1);
      check("short_err",    o_fis_err, 1);
      check("short_d2h",    o_d2h_stb, 0);
      check("short_status", o_status,  8'h45);
      check("short_error",  o_error,   8'h01);
      idle();
      check("short_err_pulse", o_fis_err, 0);

      // Unknown type 0x27, 4 words
      word(32'h27000000, 1'b0);
      check("unk_busy", o_busy, 1);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b0);
      check("unk_no_early_err", o_fis_err, 0);
      word(32'h00000000, 1'b1);
      check("unk_err", o_fis_err, 1);
      idle();

      // BIST Activate is unknown with OPT_BIST=0
      word(32'h58000000, 1'b0);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b1);
      check("bist_err", o_fis_err,  1);
      check("bist_stb", o_bist_stb, 0);
      idle();

      // Overlong D2H, 7 words
      word(32'h34401100, 1'b0);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b0);
      check("long_no_stb", o_d2h_stb, 0);
      check("long_busy",   o_busy,    1);
      word(32'h00000000, 1'b0);
      word(32'h00000000, 1'b1);
      check("long_err",    o_fis_err, 1);
      check("long_d2h",    o_d2h_stb, 0);
      check("long_status", o_status,  8'h45);
      idle();

      // Overlong DMA Activate: single-word type without last
      word(32'h39000000, 1'b0);
      check("dmalong_busy", o_busy, 1);
      word(32'h00000000, 1'b1);
      check("dmalong_err", o_fis_err,    1);
      check("dmalong_stb", o_dmaact_stb, 0);
      idle();

      // Abort mid-collect
      word(32'h34405001, 1'b0);
      word(32'h11223344, 1'b0);
      i_abort = 1'b1;
      idle();
      i_abort = 1'b0;
      check("abort_busy", o_busy,    0);
      check("abort_stb",  o_d2h_stb, 0);

      // Abort coincident with the last word suppresses the strobe
      word(32'h34405001, 1'b0);
      word(32'h11223344, 1'b0);
      word(32'h55660000, 1'b0);
      word(32'h02010000, 1'b0);
      i_abort = 1'b1;
      word(32'h00000000, 1'b1);
      i_abort = 1'b0;
      check("abort_last_stb",    o_d2h_stb, 0);
      check("abort_last_err",    o_fis_err, 0);
      check("abort_last_status", o_status,  8'h45);
      idle();

      // Asynchronous reset mid-FIS
      word(32'h34405001, 1'b0);
      word(32'h11223344, 1'b0);
      #2;
      i_reset_n = 1'b0;
      #1;
      check("arst_busy",   o_busy,   0);
      check("arst_status", o_status, 0);
      check("arst_error",  o_error,  0);
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
      idle();
      word(32'h34405001, 1'b0);
      word(32'h11223344, 1'b0);
      word(32'h55660000, 1'b0);
      word(32'h02010000, 1'b0);
      word(32'h00000000, 1'b1);
      check("arst_d2h_stb", o_d2h_stb, 1);
      check("arst_d2h_lba", o_lba,     48'h665544332211);
      check("arst_d2h_cnt", o_count,   16'h0102);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
